// File: rtl/tdi_sink_pkg.sv
// Shared types and constants for the TDI AXI-Stream sink checker:
// FSM state encoding, LFSR seed/taps and a saturating counter helper.
package tdi_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tdi_sink_lfsr.sv
// 16-bit Fibonacci LFSR, advanced every cycle; bit 0 drives pseudo-random
// backpressure on the sink's tready.
module tdi_sink_lfsr
    import tdi_sink_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic bit_out
);

    logic [15:0] q;
    logic        fb;

    assign fb      = ^(q & LFSR_TAPS);
    assign bit_out = q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/tdi_axis_sink_checker.sv
// AXI-Stream sink that checks a TDI test pattern (beat index / track index
// per beat, tlast on each line end). Optional macro TDI_SINK_THROTTLE_EN
// adds LFSR-driven backpressure on s_axis_tready.
module tdi_axis_sink_checker
    import tdi_sink_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int BEATS_PER_LINE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           sim_track_valid_line_cnt,
    input  logic [15:0]           track_num_per_wafer,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  track_done,
    output logic                  run_done,
    output logic                  busy,
    output logic                  err_data,
    output logic                  err_tlast,
    output logic                  err_overrun,
    output logic [15:0]           err_cnt,
    output logic [31:0]           line_cnt,
    output logic [15:0]           track_cnt,
    output state_t                state
);

    localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_LINE - 1);

    logic [15:0] beat_in_line;
    logic [31:0] beat_in_track;
    logic [31:0] cfg_lines;
    logic [15:0] cfg_tracks;
    logic        ready_src;
    logic        hs;
    logic        end_of_line;
    logic        last_line;
    logic        last_track;
    logic        data_bad;
    logic        tlast_bad;
    logic        unused_tdata;

    // Handshake: a beat transfers on a rising edge where s_axis_tvalid and
    // s_axis_tready are both high; tready never depends on tvalid, and it is
    // held low during reset.
`ifdef TDI_SINK_THROTTLE_EN
    tdi_sink_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .bit_out (ready_src)
    );
`else
    assign ready_src = 1'b1;
`endif

    assign s_axis_tready = ~rst & ready_src;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign busy          = (state == ST_RUN);
    assign run_done      = (state == ST_DONE);

    // Line and track ends are counted by position, never by tlast.
    assign end_of_line = (beat_in_line == LAST_BEAT);
    assign last_line   = (line_cnt == cfg_lines - 32'd1);
    assign last_track  = (track_cnt == cfg_tracks - 16'd1);
    assign data_bad    = (s_axis_tdata[31:0] != beat_in_track) ||
                         (s_axis_tdata[47:32] != track_cnt);
    assign tlast_bad   = (s_axis_tlast != end_of_line);

    assign unused_tdata = ^s_axis_tdata[DATA_WIDTH-1:48];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            beat_in_line  <= '0;
            beat_in_track <= '0;
            line_cnt      <= '0;
            track_cnt     <= '0;
            cfg_lines     <= 32'd1;
            cfg_tracks    <= 16'd1;
            track_done    <= 1'b0;
            err_data      <= 1'b0;
            err_tlast     <= 1'b0;
            err_overrun   <= 1'b0;
            err_cnt       <= '0;
        end else begin
            track_done <= 1'b0;
            if (start) begin
                // start wins over a same-cycle beat: it begins a fresh run
                state         <= ST_RUN;
                beat_in_line  <= '0;
                beat_in_track <= '0;
                line_cnt      <= '0;
                track_cnt     <= '0;
                cfg_lines     <= (sim_track_valid_line_cnt == 32'd0) ? 32'd1
                                                                     : sim_track_valid_line_cnt;
                cfg_tracks    <= (track_num_per_wafer == 16'd0) ? 16'd1
                                                                : track_num_per_wafer;
                err_data      <= 1'b0;
                err_tlast     <= 1'b0;
                err_overrun   <= 1'b0;
                err_cnt       <= '0;
            end else if (hs) begin
                if (state != ST_RUN) begin
                    err_overrun <= 1'b1;
                    err_cnt     <= sat_inc16(err_cnt);
                end else begin
                    if (data_bad) err_data <= 1'b1;
                    if (tlast_bad) err_tlast <= 1'b1;
                    if (data_bad || tlast_bad) err_cnt <= sat_inc16(err_cnt);

                    if (end_of_line) begin
                        beat_in_line <= '0;
                        if (last_line) begin
                            line_cnt      <= '0;
                            track_cnt     <= track_cnt + 16'd1;
                            beat_in_track <= '0;
                            track_done    <= 1'b1;
                            if (last_track) state <= ST_DONE;
                        end else begin
                            line_cnt      <= line_cnt + 32'd1;
                            beat_in_track <= beat_in_track + 32'd1;
                        end
                    end else begin
                        beat_in_line  <= beat_in_line + 16'd1;
                        beat_in_track <= beat_in_track + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdi_axis_sink_checker.sv
// Directed bench for tdi_axis_sink_checker: 4 beats per line, 64-bit data.
module tb_tdi_axis_sink_checker;
    import tdi_sink_pkg::*;

    localparam int DW  = 64;
    localparam int BPL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   lines_cfg;
    logic [15:0]   tracks_cfg;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          track_done;
    logic          run_done;
    logic          busy;
    logic          err_data;
    logic          err_tlast;
    logic          err_overrun;
    logic [15:0]   err_cnt;
    logic [31:0]   line_cnt;
    logic [15:0]   track_cnt;
    state_t        state;

    int n_cmp  = 0;
    int n_fail = 0;
    int td_count = 0;
    int tready_low = 0;

    tdi_axis_sink_checker #(.DATA_WIDTH(DW), .BEATS_PER_LINE(BPL)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .sim_track_valid_line_cnt (lines_cfg),
        .track_num_per_wafer      (tracks_cfg),
        .s_axis_tdata             (tdata),
        .s_axis_tvalid            (tvalid),
        .s_axis_tready            (tready),
        .s_axis_tlast             (tlast),
        .track_done               (track_done),
        .run_done                 (run_done),
        .busy                     (busy),
        .err_data                 (err_data),
        .err_tlast                (err_tlast),
        .err_overrun              (err_overrun),
        .err_cnt                  (err_cnt),
        .line_cnt                 (line_cnt),
        .track_cnt                (track_cnt),
        .state                    (state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (track_done === 1'b1) td_count++;
        if (rst === 1'b0 && tready === 1'b0) tready_low++;
    end

    function automatic logic [DW-1:0] word(input int b, input int t);
        logic [DW-1:0] w;
        w = '0;
        w[31:0]  = b[31:0];
        w[47:32] = t[15:0];
        return w;
    endfunction

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (tready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake_timeout: tready never high, required 1");
        end
    endtask

    task automatic send_clean_run(input int lines, input int tracks);
        for (int t = 0; t < tracks; t++)
            for (int b = 0; b < lines * BPL; b++)
                send_beat(word(b, t), (b % BPL) == BPL - 1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tready, busy, run_done, track_done, err_data, err_tlast, err_overrun} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {tready, busy, run_done, track_done, err_data, err_tlast, err_overrun});
        end
        n_cmp++;
        if (err_cnt !== 16'd0 || line_cnt !== 32'd0 || track_cnt !== 16'd0 || state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_counters: err_cnt=%0d line=%0d track=%0d state=%0d required 0/0/0/IDLE",
                     err_cnt, line_cnt, track_cnt, state);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal;
        int td0;
        td0 = td_count;
        lines_cfg = 32'd3; tracks_cfg = 16'd2;
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || state !== ST_RUN) begin
            n_fail++;
            $display("FAIL nominal_busy: busy=%b state=%0d required 1/RUN", busy, state);
        end
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 12; b++) begin
                send_beat(word(b, t), (b % BPL) == BPL - 1);
                if (t == 0 && b == 3) begin
                    n_cmp++;
                    if (line_cnt !== 32'd1) begin
                        n_fail++;
                        $display("FAIL nominal_line_cnt: got %0d required 1", line_cnt);
                    end
                end
                if (t == 0 && b == 11) begin
                    n_cmp++;
                    if (track_done !== 1'b1 || track_cnt !== 16'd1 || line_cnt !== 32'd0) begin
                        n_fail++;
                        $display("FAIL nominal_track_end: td=%b track=%0d line=%0d required 1/1/0",
                                 track_done, track_cnt, line_cnt);
                    end
                end
            end
        end
        n_cmp++;
        if (run_done !== 1'b1 || busy !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL nominal_done: run_done=%b busy=%b err_cnt=%0d required 1/0/0",
                     run_done, busy, err_cnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (td_count - td0 !== 2 || track_cnt !== 16'd2 || {err_data, err_tlast, err_overrun} !== 3'b0) begin
            n_fail++;
            $display("FAIL nominal_tracks: pulses=%0d track=%0d errs=%b required 2/2/000",
                     td_count - td0, track_cnt, {err_data, err_tlast, err_overrun});
        end
    endtask

    task automatic test_data_error;
        pulse_start();
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 12; b++) begin
                logic [DW-1:0] w;
                w = word(b, t);
                if (t == 0 && b == 5) w[31:0] = 32'hDEAD_0005;
                send_beat(w, (b % BPL) == BPL - 1);
                if (t == 0 && b == 4) begin
                    n_cmp++;
                    if (err_data !== 1'b0) begin
                        n_fail++;
                        $display("FAIL data_before: err_data=%b required 0", err_data);
                    end
                end
                if (t == 0 && b == 5) begin
                    n_cmp++;
                    if (err_data !== 1'b1 || err_cnt !== 16'd1) begin
                        n_fail++;
                        $display("FAIL data_flag: err_data=%b err_cnt=%0d required 1/1", err_data, err_cnt);
                    end
                end
            end
        end
        n_cmp++;
        if (run_done !== 1'b1 || err_cnt !== 16'd1 || err_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL data_done: run_done=%b err_cnt=%0d err_tlast=%b required 1/1/0",
                     run_done, err_cnt, err_tlast);
        end
    endtask

    task automatic test_tlast_error;
        pulse_start();
        n_cmp++;
        if (err_data !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL start_clears: err_data=%b err_cnt=%0d required 0/0", err_data, err_cnt);
        end
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 12; b++) begin
                logic l;
                l = (b % BPL) == BPL - 1;
                if (t == 0 && b == 2) l = 1'b1;
                if (t == 0 && b == 3) l = 1'b0;
                send_beat(word(b, t), l);
            end
        end
        n_cmp++;
        if (err_tlast !== 1'b1 || err_cnt !== 16'd2 || err_data !== 1'b0 || run_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_flags: err_tlast=%b err_cnt=%0d err_data=%b run_done=%b required 1/2/0/1",
                     err_tlast, err_cnt, err_data, run_done);
        end
    endtask

    task automatic test_overrun;
        send_beat(word(0, 2), 1'b0);
        n_cmp++;
        if (err_overrun !== 1'b1 || err_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL overrun_flag: err_overrun=%b err_cnt=%0d required 1/3", err_overrun, err_cnt);
        end
        n_cmp++;
        if (line_cnt !== 32'd0 || track_cnt !== 16'd2 || run_done !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_counters: line=%0d track=%0d run_done=%b required 0/2/1",
                     line_cnt, track_cnt, run_done);
        end
    endtask

    task automatic test_reset_midrun;
        int td0;
        pulse_start();
        for (int b = 0; b < 7; b++) send_beat(word(b, 0), (b % BPL) == BPL - 1);
        n_cmp++;
        if (line_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL midrun_line: got %0d required 1", line_cnt);
        end
        td0 = td_count;
        tdata = word(7, 0); tlast = 1'b1; tvalid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({tready, busy, run_done, track_done, err_data, err_tlast, err_overrun} !== 7'b0 ||
            err_cnt !== 16'd0 || line_cnt !== 32'd0 || track_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: flags=%b err_cnt=%0d line=%0d track=%0d required 0",
                     {tready, busy, run_done, track_done, err_data, err_tlast, err_overrun},
                     err_cnt, line_cnt, track_cnt);
        end
        tvalid = 1'b0; tlast = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        pulse_start();
        send_clean_run(3, 2);
        @(posedge clk); #1;
        n_cmp++;
        if (run_done !== 1'b1 || err_cnt !== 16'd0 || td_count - td0 !== 2) begin
            n_fail++;
            $display("FAIL midrun_restart: run_done=%b err_cnt=%0d pulses=%0d required 1/0/2",
                     run_done, err_cnt, td_count - td0);
        end
    endtask

    task automatic test_restart_and_cfg_hold;
        lines_cfg = 32'd3; tracks_cfg = 16'd2;
        pulse_start();
        for (int b = 0; b < 5; b++) send_beat(word(b, 0), (b % BPL) == BPL - 1);
        pulse_start();
        lines_cfg = 32'd9; tracks_cfg = 16'd7;
        n_cmp++;
        if (line_cnt !== 32'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: line=%0d busy=%b required 0/1", line_cnt, busy);
        end
        send_clean_run(3, 2);
        n_cmp++;
        if (run_done !== 1'b1 || err_cnt !== 16'd0 || track_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL cfg_hold: run_done=%b err_cnt=%0d track=%0d required 1/0/2",
                     run_done, err_cnt, track_cnt);
        end
    endtask

    task automatic test_zero_cfg;
        lines_cfg = 32'd0; tracks_cfg = 16'd0;
        pulse_start();
        send_clean_run(1, 1);
        n_cmp++;
        if (run_done !== 1'b1 || track_cnt !== 16'd1 || err_cnt !== 16'd0 || track_done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_cfg: run_done=%b track=%0d err_cnt=%0d td=%b required 1/1/0/1",
                     run_done, track_cnt, err_cnt, track_done);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        lines_cfg = 32'd3; tracks_cfg = 16'd2;
        @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_data_error();
        test_tlast_error();
        test_overrun();
        test_reset_midrun();
        test_restart_and_cfg_hold();
        test_zero_cfg();
`ifdef TDI_SINK_THROTTLE_EN
        n_cmp++;
        if (tready_low == 0) begin
            n_fail++;
            $display("FAIL throttle_toggle: tready low cycles=%0d required >0", tready_low);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdi_axis_sink_checker.md
TDI_AXIS_SINK_CHECKER -- requirements
Module: tdi_axis_sink_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 512, AXIS data width in bits; SHALL be a multiple of 64.
REQ-002 Parameter BEATS_PER_LINE, default 16, beats per TDI line; SHALL be 1..65535.
REQ-003 Port clk, input, 1: single clock (200 MHz domain); all logic SHALL be synchronous to its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that arms a run.
REQ-006 Port sim_track_valid_line_cnt, input, 32: lines per track.
REQ-007 Port track_num_per_wafer, input, 16: tracks per run.
REQ-008 Port s_axis_tdata, input, DATA_WIDTH: stream payload.
REQ-009 Port s_axis_tvalid, input, 1: payload valid.
REQ-010 Port s_axis_tready, output, 1: sink ready.
REQ-011 Port s_axis_tlast, input, 1: end-of-line marker.
REQ-012 Port track_done, output, 1: one-cycle pulse per completed track.
REQ-013 Port run_done, output, 1: level, all tracks received.
REQ-014 Port busy, output, 1: high in RUN.
REQ-015 Port err_data, err_tlast, err_overrun, outputs, 1 each: sticky error flags.
REQ-016 Port err_cnt, output, 16: saturating count of erroneous beats.
REQ-017 Port line_cnt, output, 32 and track_cnt, output, 16: progress counters.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE->RUN on start; RUN->DONE on the accepted final beat of track track_num_per_wafer-1; DONE->RUN on start; a start received in RUN SHALL restart the run.
REQ-020 Entering RUN SHALL clear beat, line and track counters, all error flags, err_cnt and run_done.
REQ-021 A beat SHALL be accepted only when s_axis_tvalid and s_axis_tready are both high.
REQ-022 Expected word for each accepted beat: tdata[31:0] = beat index within the track, starting at 0; tdata[47:32] = track index; a mismatch SHALL set err_data.
REQ-023 tlast SHALL be high exactly on beat index BEATS_PER_LINE-1 of each line; any deviation SHALL set err_tlast.
REQ-024 A beat accepted in IDLE or DONE SHALL set err_overrun and SHALL NOT change the counters.
REQ-025 err_cnt SHALL increment by 1 per accepted beat that has any error and SHALL saturate at 16'hFFFF.
REQ-026 Error flags and err_cnt SHALL update 1 cycle after the offending handshake.
REQ-027 line_cnt SHALL increment on the last beat of each line, counted by position and independent of tlast.
REQ-028 On the last line of a track, line_cnt SHALL wrap to 0, track_cnt SHALL increment, and track_done SHALL pulse 1 cycle later.
REQ-029 A sim_track_valid_line_cnt of 0 SHALL be treated as 1; a track_num_per_wafer of 0 SHALL be treated as 1.
REQ-030 Configuration inputs SHALL be sampled on start and held constant for the whole run.
REQ-031 run_done SHALL go high in the cycle DONE is entered and SHALL stay high until the next start or reset.
REQ-032 Without throttling, s_axis_tready SHALL be high in every non-reset cycle in all states, so overrun beats are accepted and flagged.

Reset
REQ-033 While rst is high: state = IDLE; all counters, flags, track_done, run_done and busy = 0; s_axis_tready = 0.
REQ-034 rst asserted mid-run SHALL abort the run without any track_done pulse.

Configuration
REQ-035 Macro TDI_SINK_THROTTLE_EN: when defined, s_axis_tready SHALL be driven from bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, advanced every cycle), giving pseudo-random backpressure.
REQ-036 When TDI_SINK_THROTTLE_EN is undefined, s_axis_tready SHALL be 1 outside reset, per REQ-032.

Structure
REQ-037 The FSM state enum and the LFSR seed and taps SHALL live in package tdi_sink_pkg.
REQ-038 The LFSR SHALL be sub-module tdi_sink_lfsr; all other logic SHALL be in one module.

Verification
REQ-039 BEATS_PER_LINE=4, 3 lines per track, 2 tracks, correct pattern: 2 track_done pulses, then run_done=1, err_cnt=0.
REQ-040 Corrupt tdata[31:0] on beat 5: err_data=1 one cycle later, err_cnt=1, and the run still completes.
REQ-041 tlast missing on beat 3 and asserted on beat 2: err_tlast=1, err_cnt=2.
REQ-042 A beat sent after run_done: err_overrun=1, with line_cnt and track_cnt unchanged.
REQ-043 rst asserted at beat 7: all outputs 0, s_axis_tready=0; after release, start restarts cleanly.
REQ-044 Build with TDI_SINK_THROTTLE_EN: tready toggles, the REQ-039 pattern gives the same result, and no beat is lost.
